// File: rtl/relleno_pkg.sv
// Shared types and default sizing for the cache line-fill engine.
// Holds the fill FSM state encoding used by relleno_linea.
package relleno_pkg;

    localparam int RL_ADDR_W = 4;
    localparam int RL_DATA_W = 4;
    localparam int RL_WORDS  = 4;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_EVICT,
        REQ,
        RECV,
        DONE
    } rl_state_t;

endpackage

// File: rtl/contador_envuelto.sv
// Beat counter for one line fill; idx = (start + cnt) mod WORDS, last flags the final beat.
// Latency: idx/last combinational from the count register; cnt advances on the edge after inc.
// Backpressure: none; inc simply holds the count when low.
module contador_envuelto #(
    parameter  int WORDS = 4,
    localparam int OFF_W = $clog2(WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    input  logic [OFF_W-1:0] start,
    output logic [OFF_W-1:0] idx,
    output logic             last
);

    logic [OFF_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + OFF_W'(1);
        end
    end

    // OFF_W-bit addition wraps the index around the line for free
    assign idx  = start + cnt;
    assign last = (cnt == OFF_W'(WORDS - 1));

endmodule

// File: rtl/relleno_linea.sv
// Critical-word-first cache line fill: waits out a dirty eviction, requests the line, writes beats.
// Latency: miss sampled at edge 0 -> mem_rd_req in cycle 1; each valid beat writes the cache same cycle.
// Backpressure: request held stable until mem_rd_gnt; gaps in mem_rd_valid hold the beat count.
module relleno_linea
    import relleno_pkg::*;
#(
    parameter  int ADDR_W = RL_ADDR_W,
    parameter  int DATA_W = RL_DATA_W,
    parameter  int WORDS  = RL_WORDS,
    localparam int OFF_W  = $clog2(WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_req,
    input  logic [ADDR_W-1:0] miss_addr,
    input  logic              victim_dirty,
    input  logic              evict_done,
    output logic              mem_rd_req,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic              mem_rd_gnt,
    input  logic              mem_rd_valid,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              cache_we,
    output logic [OFF_W-1:0]  cache_widx,
    output logic [DATA_W-1:0] cache_wdata,
    output logic              crit_ready,
    output logic              fill_done,
    output logic              busy
);

    rl_state_t         state;
    logic [ADDR_W-1:0] addr_q;
    logic [OFF_W-1:0]  start;
    logic [OFF_W-1:0]  idx;
    logic              last;
    logic              beat;

    assign start = addr_q[OFF_W-1:0];
    assign beat  = (state == RECV) && mem_rd_valid;

    contador_envuelto #(
        .WORDS (WORDS)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (state == IDLE),
        .inc   (beat),
        .start (start),
        .idx   (idx),
        .last  (last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            addr_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss_req) begin
                        // The miss address is already {tag, critical offset}
                        addr_q <= miss_addr;
                        state  <= victim_dirty ? WAIT_EVICT : REQ;
                    end
                end
                WAIT_EVICT: begin
                    if (evict_done) begin
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (mem_rd_gnt) begin
                        state <= RECV;
                    end
                end
                RECV: begin
                    if (beat && last) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign mem_rd_req  = (state == REQ);
    assign mem_rd_addr = addr_q;
    assign busy        = (state != IDLE);

    // Cache write port is combinational on the beat so the data is never re-registered
    assign cache_we    = beat;
    assign cache_widx  = beat ? idx : '0;
    assign cache_wdata = beat ? mem_rd_data : '0;
    assign crit_ready  = beat && (idx == start);
    assign fill_done   = beat && last;

endmodule

// File: tb/tb_relleno_linea.sv
// Directed bench for relleno_linea: clean, dirty, stalled/gappy, wrapped, reset and spurious cases.
module tb_relleno_linea;

    logic       clk;
    logic       rst;
    logic       miss_req;
    logic [3:0] miss_addr;
    logic       victim_dirty;
    logic       evict_done;
    logic       mem_rd_req;
    logic [3:0] mem_rd_addr;
    logic       mem_rd_gnt;
    logic       mem_rd_valid;
    logic [3:0] mem_rd_data;
    logic       cache_we;
    logic [1:0] cache_widx;
    logic [3:0] cache_wdata;
    logic       crit_ready;
    logic       fill_done;
    logic       busy;

    int checks = 0;
    int errors = 0;

    relleno_linea #(
        .ADDR_W (4),
        .DATA_W (4),
        .WORDS  (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .miss_req     (miss_req),
        .miss_addr    (miss_addr),
        .victim_dirty (victim_dirty),
        .evict_done   (evict_done),
        .mem_rd_req   (mem_rd_req),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_gnt   (mem_rd_gnt),
        .mem_rd_valid (mem_rd_valid),
        .mem_rd_data  (mem_rd_data),
        .cache_we     (cache_we),
        .cache_widx   (cache_widx),
        .cache_wdata  (cache_wdata),
        .crit_ready   (crit_ready),
        .fill_done    (fill_done),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // exp_idx packs the expected write index of beat k in bits [2k+1:2k]
    task automatic run_fill(input logic [3:0] addr, input logic dirty, input int ev_wait,
                            input int gnt_wait, input logic [15:0] vpat, input logic [7:0] exp_idx);
        int beat;
        beat = 0;
        @(negedge clk);
        miss_req = 1'b1; miss_addr = addr; victim_dirty = dirty;
        #1;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_req", 32'(mem_rd_req), 32'd0);
        if (dirty) begin
            for (int i = 0; i < ev_wait; i++) begin
                @(negedge clk);
                miss_req = 1'b0;
                evict_done = (i == ev_wait - 1);
                #1;
                chk("evict_req", 32'(mem_rd_req), 32'd0);
                chk("evict_busy", 32'(busy), 32'd1);
            end
        end
        for (int g = 0; g <= gnt_wait; g++) begin
            @(negedge clk);
            miss_req = 1'b0; evict_done = 1'b0;
            mem_rd_gnt = (g == gnt_wait);
            #1;
            chk("req", 32'(mem_rd_req), 32'd1);
            chk("req_addr", 32'(mem_rd_addr), 32'(addr));
            chk("req_busy", 32'(busy), 32'd1);
        end
        for (int j = 0; j < 16 && beat < 4; j++) begin
            @(negedge clk);
            mem_rd_gnt = 1'b0;
            mem_rd_valid = vpat[j];
            mem_rd_data = 4'hA + beat[3:0];
            #1;
            chk("we", 32'(cache_we), 32'(vpat[j]));
            chk("recv_busy", 32'(busy), 32'd1);
            if (vpat[j]) begin
                chk("widx", 32'(cache_widx), 32'(exp_idx[2*beat +: 2]));
                chk("wdata", 32'(cache_wdata), 32'(4'hA + beat[3:0]));
                chk("crit", 32'(crit_ready), 32'(beat == 0));
                chk("done", 32'(fill_done), 32'(beat == 3));
                beat++;
            end else begin
                chk("gap_done", 32'(fill_done), 32'd0);
            end
        end
        chk("beats", 32'(beat), 32'd4);
        @(negedge clk);
        mem_rd_valid = 1'b0;
        #1;
        chk("done_busy", 32'(busy), 32'd1);
        chk("done_we", 32'(cache_we), 32'd0);
        @(negedge clk);
        #1;
        chk("back_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; miss_req = 1'b0; miss_addr = '0; victim_dirty = 1'b0;
        evict_done = 1'b0; mem_rd_gnt = 1'b0; mem_rd_valid = 1'b0; mem_rd_data = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req", 32'(mem_rd_req), 32'd0);
        chk("rst_addr", 32'(mem_rd_addr), 32'd0);
        chk("rst_we", 32'(cache_we), 32'd0);
        chk("rst_done", 32'(fill_done), 32'd0);
        chk("rst_crit", 32'(crit_ready), 32'd0);

        // Clean miss, offset 2: order 2,3,0,1
        run_fill(4'b0110, 1'b0, 0, 0, 16'h000F, 8'h4E);
        // Dirty victim, evict_done 5 cycles after the miss
        run_fill(4'b1100, 1'b1, 5, 0, 16'h000F, 8'hE4);
        // Grant stalled 3 cycles, valid pattern 1,0,0,1,1,0,1; offset 1: order 1,2,3,0
        run_fill(4'b1001, 1'b0, 0, 3, 16'h0059, 8'h39);
        // Top offset wraps: order 3,0,1,2
        run_fill(4'b0011, 1'b0, 0, 0, 16'h000F, 8'h93);

        // Reset after two beats abandons the fill
        @(negedge clk);
        miss_req = 1'b1; miss_addr = 4'b0101; victim_dirty = 1'b0;
        @(negedge clk);
        miss_req = 1'b0; mem_rd_gnt = 1'b1;
        @(negedge clk);
        mem_rd_gnt = 1'b0; mem_rd_valid = 1'b1; mem_rd_data = 4'h1;
        #1;
        chk("rm_we0", 32'(cache_we), 32'd1);
        chk("rm_idx0", 32'(cache_widx), 32'd1);
        @(negedge clk);
        mem_rd_data = 4'h2;
        #1;
        chk("rm_idx1", 32'(cache_widx), 32'd2);
        @(negedge clk);
        mem_rd_valid = 1'b0; rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            rst = 1'b0; mem_rd_valid = 1'b1; mem_rd_data = 4'h3 + 4'(k);
            #1;
            chk("rm_no_we", 32'(cache_we), 32'd0);
            chk("rm_busy", 32'(busy), 32'd0);
            chk("rm_no_done", 32'(fill_done), 32'd0);
        end
        @(negedge clk);
        mem_rd_valid = 1'b0;
        // Restart after reset must begin with cnt=0: offset 0 order 0,1,2,3
        run_fill(4'b0000, 1'b0, 0, 0, 16'h000F, 8'hE4);

        // Spurious valid and evict_done while idle
        @(negedge clk);
        mem_rd_valid = 1'b1; evict_done = 1'b1; mem_rd_data = 4'h7;
        #1;
        chk("sp_we", 32'(cache_we), 32'd0);
        chk("sp_busy", 32'(busy), 32'd0);
        @(negedge clk);
        mem_rd_valid = 1'b0; evict_done = 1'b0;
        #1;
        chk("sp_idle", 32'(busy), 32'd0);
        chk("sp_req", 32'(mem_rd_req), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
